// File: rtl/pc_fetch.sv
// pc_fetch - program counter and instruction-fetch sequencer.
//
// Owns the PC and is the requesting side of the instruction-memory port.
// One fetch at a time: the PC is issued on imem_addr with imem_req, the
// returned word is latched together with the PC it came from, then offered
// to decode through a valid/ready handshake.  When decode accepts, the next
// PC is chosen from decode's PCsrc/ImmOp (branch) or PC+4 (sequential).
//
// Ports
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   stall         1 = do not launch a new fetch (ignored once a fetch is in flight)
//   imem_req      fetch request, held until imem_ack
//   imem_addr     fetch address, equal to the PC register
//   imem_ack      memory returns imem_rdata this cycle
//   imem_rdata    fetched instruction word
//   instr_valid   instr/pc_out are valid for decode
//   instr_ready   decode accepts instr this cycle
//   instr         registered instruction word
//   pc_out        PC of the presented instruction
//   PCsrc, ImmOp  branch taken / signed branch offset, sampled on the accept cycle
//   misalign_err  one-cycle pulse when a taken branch target was not 4-byte aligned

module pc_fetch #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = {ADDRESS_WIDTH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] pc_out,
  input  logic                     PCsrc,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt;
  logic [ADDRESS_WIDTH-1:0] pc_r;
  logic [ADDRESS_WIDTH-1:0] pc_nxt;
  logic                     req_nxt;
  logic                     valid_nxt;
  logic [DATA_WIDTH-1:0]    instr_nxt;
  logic [ADDRESS_WIDTH-1:0] pc_out_nxt;
  logic                     err_nxt;

  logic [ADDRESS_WIDTH-1:0] imm_ext;
  logic [ADDRESS_WIDTH-1:0] seq_pc;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     accept;

  // The offset is signed: the size cast sign-extends when the address is
  // wider than the data path and truncates when it is narrower.
  assign imm_ext   = ADDRESS_WIDTH'($signed(ImmOp));
  assign seq_pc    = pc_r + {{(ADDRESS_WIDTH-3){1'b0}}, 3'd4};
  assign target    = PCsrc ? (pc_r + imm_ext) : seq_pc;
  assign accept    = instr_valid & instr_ready;
  assign imem_addr = pc_r;

  // Next-state and next-register values for the fetch sequencer.
  always_comb begin
    state_nxt  = state_r;
    pc_nxt     = pc_r;
    req_nxt    = imem_req;
    valid_nxt  = instr_valid;
    instr_nxt  = instr;
    pc_out_nxt = pc_out;
    err_nxt    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!stall) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
        end else begin
          req_nxt   = 1'b0;
        end
      end
      // stall is deliberately not looked at here: an issued request must finish.
      REQ: begin
        if (imem_ack) begin
          instr_nxt  = imem_rdata;
          pc_out_nxt = pc_r;
          req_nxt    = 1'b0;
          valid_nxt  = 1'b1;
          state_nxt  = HOLD;
        end else begin
          req_nxt    = 1'b1;
        end
      end
      HOLD: begin
        if (accept) begin
          // The PC is always kept word aligned; an unaligned branch target is
          // reported rather than fetched.
          pc_nxt    = {target[ADDRESS_WIDTH-1:2], 2'b00};
          err_nxt   = PCsrc & (|target[1:0]);
          valid_nxt = 1'b0;
          if (!stall) begin
            state_nxt = REQ;
            req_nxt   = 1'b1;
          end else begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end
        end else begin
          valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      instr        <= {DATA_WIDTH{1'b0}};
      pc_out       <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      pc_r         <= pc_nxt;
      imem_req     <= req_nxt;
      instr_valid  <= valid_nxt;
      instr        <= instr_nxt;
      pc_out       <= pc_out_nxt;
      misalign_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch - self-checking bench for pc_fetch.
// A small instruction memory returns a word derived from the address; the
// expected PC sequence is tracked with plain arithmetic on a 32-bit PC.

module tb_pc_fetch;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] pc_out;
  logic          PCsrc;
  logic [DW-1:0] ImmOp;
  logic          misalign_err;

  int            n_checks = 0;
  int            n_fails  = 0;
  logic [31:0]   exp_pc;

  always #5 clk = ~clk;

  pc_fetch #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .RESET_PC     (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc_out      (pc_out),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .misalign_err(misalign_err)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a fetch request.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (imem_req === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  // Memory side of one fetch: wait for the request, hold ack off for
  // 'delay' cycles, then return the word for the requested address.
  task automatic complete_fetch(input int delay, output bit ok);
    wait_req(ok);
    if (ok) begin
      repeat (delay) tick();
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      tick();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  // Decode side: accept the presented word with the given branch decision.
  task automatic accept(input logic br, input logic [31:0] imm);
    PCsrc       = br;
    ImmOp       = imm;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    PCsrc       = 1'b0;
    ImmOp       = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = 32'h0;
    repeat (3) tick();
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: req=%b valid=%b err=%b, expected 0 0 0", imem_req, instr_valid, misalign_err);
    end
    n_checks++;
    if (instr !== 32'h0 || pc_out !== RESET_PC || imem_addr !== RESET_PC) begin
      n_fails++;
      $display("FAIL reset_data: instr=%h pc_out=%h addr=%h, expected 0 %h %h", instr, pc_out, imem_addr, RESET_PC, RESET_PC);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_stall_idle: req=%b, expected 0", imem_req);
    end
    exp_pc = RESET_PC;
  endtask

  task automatic test_sequential();
    bit ok;
    stall = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fails++;
      $display("FAIL seq_first_req: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
    for (int i = 0; i < 4; i++) begin
      complete_fetch(0, ok);
      n_checks++;
      if (!ok || instr_valid !== 1'b1 || instr !== mem_word(exp_pc) || pc_out !== exp_pc || misalign_err !== 1'b0) begin
        n_fails++;
        $display("FAIL seq_present: ok=%0d valid=%b instr=%h pc_out=%h, expected 1 1 %h %h", ok, instr_valid, instr, pc_out, mem_word(exp_pc), exp_pc);
      end
      accept(1'b0, $urandom);
      exp_pc = exp_pc + 32'd4;
      n_checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc || misalign_err !== 1'b0) begin
        n_fails++;
        $display("FAIL seq_turnaround: valid=%b req=%b addr=%h err=%b, expected 0 1 %h 0", instr_valid, imem_req, imem_addr, misalign_err, exp_pc);
      end
    end
  endtask

  task automatic test_branch();
    bit ok;
    for (int i = 0; i < 2; i++) begin
      complete_fetch(0, ok);
      n_checks++;
      if (!ok || pc_out !== exp_pc || instr !== mem_word(exp_pc)) begin
        n_fails++;
        $display("FAIL br_present: ok=%0d pc_out=%h instr=%h, expected %h %h", ok, pc_out, instr, exp_pc, mem_word(exp_pc));
      end
      accept(1'b1, 32'hFFFF_FFF8);
      exp_pc = exp_pc - 32'd8;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || misalign_err !== 1'b0) begin
        n_fails++;
        $display("FAIL br_back8: req=%b addr=%h err=%b, expected 1 %h 0", imem_req, imem_addr, misalign_err, exp_pc);
      end
    end
  endtask

  task automatic test_misalign();
    bit ok;
    complete_fetch(0, ok);
    accept(1'b0, 32'h0);
    complete_fetch(0, ok);
    n_checks++;
    if (!ok || pc_out !== 32'h4) begin
      n_fails++;
      $display("FAIL mis_at4: ok=%0d pc_out=%h, expected 4", ok, pc_out);
    end
    accept(1'b1, 32'd6);
    n_checks++;
    if (misalign_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_fails++;
      $display("FAIL mis_pulse: err=%b req=%b addr=%h, expected 1 1 8", misalign_err, imem_req, imem_addr);
    end
    tick();
    n_checks++;
    if (misalign_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_fails++;
      $display("FAIL mis_one_cycle: err=%b req=%b addr=%h, expected 0 1 8", misalign_err, imem_req, imem_addr);
    end
    exp_pc = 32'h8;
  endtask

  task automatic test_ack_delay();
    for (int i = 0; i < 3; i++) begin
      imem_rdata = $urandom;
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
        n_fails++;
        $display("FAIL ackdly_hold: req=%b addr=%h valid=%b, expected 1 %h 0", imem_req, imem_addr, instr_valid, exp_pc);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(imem_addr);
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL ackdly_ack_cycle: valid=%b, expected 0", instr_valid);
    end
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== mem_word(exp_pc) || pc_out !== exp_pc) begin
      n_fails++;
      $display("FAIL ackdly_present: valid=%b instr=%h pc_out=%h, expected 1 %h %h", instr_valid, instr, pc_out, mem_word(exp_pc), exp_pc);
    end
    accept(1'b0, 32'h0);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_backpressure();
    bit ok;
    complete_fetch(0, ok);
    for (int i = 0; i < 4; i++) begin
      imem_ack   = 1'(i % 2);
      imem_rdata = $urandom;
      tick();
      n_checks++;
      if (!ok || instr_valid !== 1'b1 || instr !== mem_word(exp_pc) || pc_out !== exp_pc || imem_req !== 1'b0) begin
        n_fails++;
        $display("FAIL bp_stable: valid=%b instr=%h pc_out=%h req=%b, expected 1 %h %h 0", instr_valid, instr, pc_out, imem_req, mem_word(exp_pc), exp_pc);
      end
    end
    imem_ack = 1'b0;
    stall    = 1'b1;
    accept(1'b0, 32'h0);
    exp_pc = exp_pc + 32'd4;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_stall_accept: valid=%b req=%b, expected 0 0", instr_valid, imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b0 || imem_addr !== exp_pc) begin
        n_fails++;
        $display("FAIL bp_idle: req=%b addr=%h, expected 0 %h", imem_req, imem_addr, exp_pc);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      n_fails++;
      $display("FAIL bp_resume: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, exp_pc);
    end
  endtask

  task automatic test_reset_midfetch();
    bit ok;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_async: req=%b addr=%h valid=%b, expected 0 %h 0", imem_req, imem_addr, instr_valid, RESET_PC);
    end
    tick();
    rst_n      = 1'b1;
    stall      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_late_ack: req=%b addr=%h valid=%b, expected 1 %h 0", imem_req, imem_addr, instr_valid, RESET_PC);
    end
    exp_pc = RESET_PC;
    complete_fetch(0, ok);
    n_checks++;
    if (!ok || instr !== mem_word(exp_pc) || pc_out !== exp_pc) begin
      n_fails++;
      $display("FAIL rst_first_fetch: ok=%0d instr=%h pc_out=%h, expected %h %h", ok, instr, pc_out, mem_word(exp_pc), exp_pc);
    end
    accept(1'b0, 32'h0);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_random();
    int          ack_dly;
    int          ready_dly;
    int          idle;
    logic        br;
    logic        sa;
    logic        e;
    logic [31:0] imm;
    logic [31:0] tgt;
    for (int t = 0; t < 80; t++) begin
      ack_dly   = $urandom_range(0, 3);
      ready_dly = $urandom_range(0, 3);
      br        = 1'($urandom_range(0, 1));
      sa        = ($urandom_range(0, 3) == 0);
      imm       = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 64) - 32);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        n_fails++;
        $display("FAIL rnd_req: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, exp_pc);
      end
      for (int k = 0; k < ack_dly; k++) begin
        stall      = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
          n_fails++;
          $display("FAIL rnd_wait: req=%b addr=%h valid=%b, expected 1 %h 0", imem_req, imem_addr, instr_valid, exp_pc);
        end
      end
      stall      = 1'($urandom_range(0, 1));
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      tick();
      imem_ack   = 1'b0;
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== mem_word(exp_pc) || pc_out !== exp_pc || imem_req !== 1'b0 || misalign_err !== 1'b0) begin
        n_fails++;
        $display("FAIL rnd_present: valid=%b instr=%h pc_out=%h req=%b err=%b, expected 1 %h %h 0 0", instr_valid, instr, pc_out, imem_req, misalign_err, mem_word(exp_pc), exp_pc);
      end
      for (int k = 0; k < ready_dly; k++) begin
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        stall      = 1'($urandom_range(0, 1));
        PCsrc      = 1'($urandom_range(0, 1));
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== mem_word(exp_pc) || pc_out !== exp_pc || imem_req !== 1'b0) begin
          n_fails++;
          $display("FAIL rnd_backpressure: valid=%b instr=%h pc_out=%h req=%b, expected 1 %h %h 0", instr_valid, instr, pc_out, imem_req, mem_word(exp_pc), exp_pc);
        end
      end
      imem_ack = 1'b0;
      stall    = sa;
      accept(br, imm);
      tgt    = br ? (exp_pc + imm) : (exp_pc + 32'd4);
      e      = br && ((tgt % 4) != 0);
      exp_pc = tgt - (tgt % 4);
      n_checks++;
      if (instr_valid !== 1'b0 || misalign_err !== e || imem_req !== !sa || imem_addr !== exp_pc) begin
        n_fails++;
        $display("FAIL rnd_accept: valid=%b err=%b req=%b addr=%h, expected 0 %b %b %h", instr_valid, misalign_err, imem_req, imem_addr, e, !sa, exp_pc);
      end
      if (sa) begin
        idle = $urandom_range(1, 3);
        for (int k = 0; k < idle; k++) begin
          imem_ack   = 1'($urandom_range(0, 1));
          imem_rdata = $urandom;
          tick();
          n_checks++;
          if (imem_req !== 1'b0 || misalign_err !== 1'b0 || instr_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL rnd_idle: req=%b err=%b valid=%b, expected 0 0 0", imem_req, misalign_err, instr_valid);
          end
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
          n_fails++;
          $display("FAIL rnd_resume: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, exp_pc);
        end
      end
      stall = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_misalign();
    test_ack_delay();
    test_backpressure();
    test_reset_midfetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
